booth_mul_seq: RTL and testbench

Sequential signed multiplier using radix-4 Booth recoding. It produces the 64-bit HI/LO product for the ALU's MUL instruction. It is the inverse datapath to the existing signed divider: it computes what the divider undoes, so that product + remainder = dividend can be cross-checked. It retires one Booth digit per clock and uses a start/busy/done handshake toward the control unit.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/booth_r4_recode.sv | 22 ++
 rtl/booth_mul_seq.sv | 135 +++++++++++++
 tb/tb_booth_mul_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states, default operand width and
// the radix-4 Booth select codes used by the sequential and array multipliers.
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mul_state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_sel_t;

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: maps a multiplier triplet {q[2i+1], q[2i], q[2i-1]}
// to the partial-product select code.
module booth_r4_recode
    import alu_pkg::*;
(
    input  logic [2:0] triplet,
    output logic [2:0] sel
);

    always_comb begin
        sel = ZERO;
        unique case (triplet)
            3'b000, 3'b111: sel = ZERO;
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-4 Booth multiplier: one Booth digit per clock,
// producing the exact 2*WIDTH-bit product on hi/lo.
module booth_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITER = WIDTH / 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int AW   = WIDTH + 2;

    // Handshake: start is sampled only while busy is low; an accepted start
    // raises busy from the next cycle, and done pulses for one cycle after
    // the final iteration, with hi/lo valid from that cycle until the next done.

    mul_state_t       state, state_nx;
    logic             load, step, finish;

    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_m1;
    logic [CW-1:0]    cnt;
    logic             done_r;
    logic [WIDTH-1:0] hi_r, lo_r;

    logic [2:0]       sel_raw;
    booth_sel_t       sel;
    logic [AW-1:0]    m_ext, pp, sum, acc_sh;
    logic [WIDTH-1:0] q_sh;
    logic             last;

    booth_r4_recode u_recode (
        .triplet ({q_reg[1], q_reg[0], q_m1}),
        .sel     (sel_raw)
    );

    assign sel   = booth_sel_t'(sel_raw);
    assign m_ext = {{2{m_reg[WIDTH-1]}}, m_reg};

    always_comb begin
        pp = '0;
        unique case (sel)
            ZERO:    pp = '0;
            POS1:    pp = m_ext;
            POS2:    pp = m_ext << 1;
            NEG1:    pp = -m_ext;
            NEG2:    pp = -(m_ext << 1);
            default: pp = '0;
        endcase
    end

    // The {acc, q} pair shifts right arithmetically by two after each add.
    assign sum    = acc + pp;
    assign acc_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign q_sh   = {sum[1:0], q_reg[WIDTH-1:2]};
    assign last   = (cnt == CW'(ITER - 1));

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            acc    <= '0;
            m_reg  <= '0;
            q_reg  <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= finish;
            if (load) begin
                m_reg <= multiplicand;
                q_reg <= multiplier;
                q_m1  <= 1'b0;
                acc   <= '0;
                cnt   <= '0;
            end else if (step) begin
                acc   <= acc_sh;
                q_reg <= q_sh;
                q_m1  <= q_reg[1];
                cnt   <= cnt + CW'(1);
            end
            // After ITER double-shifts the low half of acc holds the product's upper word.
            if (finish) begin
                hi_r <= acc_sh[WIDTH-1:0];
                lo_r <= q_sh;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: hand-computed products, latency,
// busy-start ignore, clear abort and back-to-back restart.
module tb_booth_mul_seq;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];

    booth_mul_seq #(.WIDTH(32)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard: every done pulse must match the oldest expected product
    always @(negedge clock) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                check("product", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic [31:0] m, input logic [31:0] q,
                            input logic [63:0] exp, input bit push, output int t0);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        if (push) exp_q.push_back(exp);
        step();
        t0    = cyc;
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(output int t_done);
        t_done = -1;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                t_done = cyc;
                break;
            end
            step();
        end
        if (t_done < 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                          input logic [63:0] exp);
        int t0, td;
        start_op(m, q, exp, 1'b1, t0);
        wait_done(td);
        check({tag, "_latency"}, 64'(td - t0), 64'd16);
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        step();
        check({tag, "_hold"}, {hi, lo}, exp);
    endtask

    initial begin
        int t0, td, td1, td2, dc;
        logic [31:0] lo_first;

        clear        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) step();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        clear = 1'b0;
        step();

        run_op("p100x3",    32'd100,        32'd3,          64'h00000000_0000012C);
        run_op("p100xm3",   32'd100,        32'hFFFFFFFD,   64'hFFFFFFFF_FFFFFED4);
        run_op("m100xm3",   32'hFFFFFF9C,   32'hFFFFFFFD,   64'h00000000_0000012C);
        run_op("min_x_min", 32'h80000000,   32'h80000000,   64'h40000000_00000000);
        run_op("max_x_max", 32'h7FFFFFFF,   32'h7FFFFFFF,   64'h3FFFFFFF_00000001);
        run_op("min_x_m1",  32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000);

        // start while busy is ignored and inputs changing mid-run do not matter
        dc = done_cnt;
        start_op(32'd5, 32'd20, 64'd100, 1'b1, t0);
        repeat (4) step();
        start        = 1'b1;
        multiplicand = 32'd7;
        multiplier   = 32'd7;
        step();
        start = 1'b0;
        wait_done(td);
        check("busy_start_latency", 64'(td - t0), 64'd16);
        repeat (20) step();
        check("busy_start_single_done", 64'(done_cnt - dc), 64'd1);
        check("busy_start_idle", {63'd0, busy}, 64'd0);

        // clear mid-operation aborts with no done pulse
        dc = done_cnt;
        start_op(32'd1234, 32'd5678, 64'd0, 1'b0, t0);
        repeat (7) step();
        clear = 1'b1;
        step();
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        clear = 1'b0;
        repeat (20) step();
        check("abort_no_done", 64'(done_cnt - dc), 64'd0);
        run_op("zero_x7", 32'd0, 32'd7, 64'd0);

        // back-to-back: restart in the done cycle
        start_op(32'd33, 32'd3, 64'd99, 1'b1, t0);
        wait_done(td1);
        lo_first = lo;
        check("b2b_first_latency", 64'(td1 - t0), 64'd16);
        start_op(32'd20, 32'd20, 64'd400, 1'b1, t0);
        check("b2b_hold_prev", {hi, lo}, 64'd99);
        wait_done(td2);
        check("b2b_spacing", 64'(td2 - td1), 64'd17);
        check("div_xcheck", 64'(lo_first + 32'd1), 64'd100);
        step();

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
